reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement stage directly upstream of the register file write port 1 (retirement port).
//  Allocates up to 4 entries/cycle in program order; tag = entry index = 4-bit owner id.
//  Captures up to 4 execution results/cycle and retires up to 4 oldest completed entries/cycle.
//  Retirement outputs match the register file retirement port bit-for-bit.
//  Flat buses: slot 0 sits in the MSBs (slot i at bits [W*(3-i)+W-1 : W*(3-i)]).
// PARAMETERS
//  DEPTH   16  entries; power of 2, equal to 2**TAG_W
//  TAG_W   4   tag/owner width
//  DATA_W  16  register value width
// PORTS
//  clk                                in   1   clock; all state updates on posedge
//  rst                                in   1   synchronous, active-high reset
//  flush                              in   1   discard all entries (mispredict recovery)
//  alloc_valid                        in   1   allocation request this cycle
//  alloc_count                        in   3   number of slots allocated, 0..4, taken from slot 0 upward
//  alloc_has_dest_flat                in   4   per slot: instruction writes a register
//  alloc_dest_flat                    in   16  per slot: 4-bit destination register
//  alloc_ready                        out  1   free entries >= 4 (combinational from count)
//  alloc_tag_flat                     out  16  per slot: tag = (tail+i) mod DEPTH (combinational)
//  cdb_valid_flat                     in   4   per lane: result valid
//  cdb_tag_flat                       in   16  per lane: tag of the completing entry
//  cdb_data_flat                      in   64  per lane: 16-bit result
//  retirement_write_data_enable_flat  out  4   per slot: register write strobe (registered)
//  retirement_target_reg_flat         out  16  per slot: destination register
//  retirement_write_data_flat         out  64  per slot: value
//  instruction_writer_flat            out  16  per slot: tag of the retiring entry
//  rob_count                          out  5   occupied entries, 0..16
//  rob_empty / rob_full               out  1   count==0 / count==DEPTH
// BEHAVIOUR
//  State: per-entry valid, done, has_dest, dest[3:0], data[15:0]; head, tail (TAG_W-bit, wrap mod DEPTH); count (5 bits).
//  Reset (rst=1 at posedge): all valid/done=0, head=tail=0, count=0; all retirement outputs = 0.
//  Priority per edge: rst > flush > {commit, complete, alloc}.
//  flush: same as reset for state and outputs; alloc/cdb inputs that cycle are ignored.
//  Alloc: accepted only if alloc_valid && alloc_ready.
//   - Slots 0..alloc_count-1 are written at tail+i: valid=1, done=0.
//   - tail += alloc_count.
//   - Request with alloc_ready=0 is dropped entirely: no partial allocation.
//  Complete: per lane with cdb_valid, if entry[tag].valid, set done=1 and data=cdb_data.
//   - Completion for an invalid entry is ignored.
//   - Two lanes with the same tag in one cycle: the higher lane index wins.
//  Commit: evaluated on state before the edge.
//   - k = number of consecutive valid&&done entries from head, capped at 4.
//   - Those entries are cleared and head += k.
//   - Registered outputs for slot i<k: enable = has_dest; target, data and writer = entry values.
//   - Slots >= k: enable=0; other fields don't-care, driven 0.
//   - Outputs are valid for exactly one cycle; latency is cdb edge N -> retirement output after edge N+1.
//  Entries without a destination retire in order with enable=0 but still consume a commit slot.
//  count_next = count + accepted_alloc - k. Alloc and commit may occur in the same cycle, including at wrap-around.
//  An entry allocated this cycle cannot commit this cycle, because done=0.
//  Occupied ring entries are never overwritten: alloc_ready guarantees >=4 free entries.
// TESTING
//  1. rst, then alloc 4 (dest r1..r4, tags 0..3); cdb tags 3,2,1,0 in one cycle, data 10,20,30,40.
//     -> next+1 cycle: enable=4'b1111, targets 1,2,3,4, data 40,30,20,10, writers 0,1,2,3; count -> 0.
//  2. Alloc tags 0,1; complete tag 1 only.
//     -> no retirement; then complete tag 0 -> slot0=tag0, slot1=tag1 retire together.
//  3. Fill to 13 entries.
//     -> alloc_ready=0; alloc request ignored with tail unchanged; retiring 1 entry restores alloc_ready.
//  4. Wrap: head=tail=14, alloc 4.
//     -> tags 14,15,0,1; complete all -> retire in order 14,15,0,1; head=2.
//  5. Alloc with has_dest=0 on slot 1, all done.
//     -> enable=4'b1011 for that group, writer order preserved.
//  6. flush asserted with 6 entries pending plus a cdb in the same cycle.
//     -> count=0, rob_empty=1, no retirement ever issued for those tags.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates up to four entries per cycle in program order, captures up to four
// execution results per cycle and retires up to four oldest completed entries per cycle onto the
// register file retirement port. Flat buses carry slot 0 in the most significant field.
module reorder_buffer #(
   parameter int unsigned Depth = 16,
   parameter int unsigned TagW  = 4,
   parameter int unsigned DataW = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 alloc_valid_i,
   input  logic [2:0]           alloc_count_i,
   input  logic [3:0]           alloc_has_dest_flat_i,
   input  logic [15:0]          alloc_dest_flat_i,
   output logic                 alloc_ready_o,
   output logic [4*TagW-1:0]    alloc_tag_flat_o,
   input  logic [3:0]           cdb_valid_flat_i,
   input  logic [4*TagW-1:0]    cdb_tag_flat_i,
   input  logic [4*DataW-1:0]   cdb_data_flat_i,
   output logic [3:0]           retirement_write_data_enable_flat_o,
   output logic [15:0]          retirement_target_reg_flat_o,
   output logic [4*DataW-1:0]   retirement_write_data_flat_o,
   output logic [4*TagW-1:0]    instruction_writer_flat_o,
   output logic [TagW:0]        rob_count_o,
   output logic                 rob_empty_o,
   output logic                 rob_full_o
);

   // Per-entry state
   logic [Depth-1:0] valid_q, valid_d;
   logic [Depth-1:0] done_q, done_d;
   logic [Depth-1:0] has_dest_q, has_dest_d;
   logic [3:0]       dest_q [Depth];
   logic [3:0]       dest_d [Depth];
   logic [DataW-1:0] data_q [Depth];
   logic [DataW-1:0] data_d [Depth];

   // Ring pointers and occupancy
   logic [TagW-1:0] head_q, head_d;
   logic [TagW-1:0] tail_q, tail_d;
   logic [TagW:0]   count_q, count_d;

   // Registered retirement port
   logic [3:0]         ret_en_q, ret_en_d;
   logic [15:0]        ret_tgt_q, ret_tgt_d;
   logic [4*DataW-1:0] ret_data_q, ret_data_d;
   logic [4*TagW-1:0]  ret_wr_q, ret_wr_d;

   logic [TagW:0] commit_n;
   logic [TagW:0] alloc_n;

   // Free space of at least four entries guarantees a full-width allocation never overwrites
   assign alloc_ready_o = (count_q <= (TagW+1)'(Depth - 4));
   assign rob_count_o   = count_q;
   assign rob_empty_o   = (count_q == '0);
   assign rob_full_o    = (count_q == (TagW+1)'(Depth));

   assign retirement_write_data_enable_flat_o = ret_en_q;
   assign retirement_target_reg_flat_o        = ret_tgt_q;
   assign retirement_write_data_flat_o        = ret_data_q;
   assign instruction_writer_flat_o           = ret_wr_q;

   // Tags offered to the allocator: consecutive entries starting at tail
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         alloc_tag_flat_o[TagW*(3-i) +: TagW] = tail_q + TagW'(i);
      end
   end

   // Accepted allocation size; requests above four are clamped, unready requests dropped whole
   always_comb begin
      alloc_n = '0;
      if (alloc_valid_i && alloc_ready_o) begin
         alloc_n = (alloc_count_i > 3'd4) ? (TagW+1)'(4) : (TagW+1)'(alloc_count_i);
      end
   end

   // Commit width: run of valid and done entries from head, at most four
   always_comb begin
      logic [TagW-1:0] idx;
      logic            run;
      commit_n = '0;
      run      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idx = head_q + TagW'(i);
         run = run & valid_q[idx] & done_q[idx];
         if (run) commit_n = (TagW+1)'(i + 1);
      end
   end

   // Next state: capture retirement from pre-edge state, then complete, clear, allocate
   always_comb begin
      logic [TagW-1:0] idx;
      valid_d    = valid_q;
      done_d     = done_q;
      has_dest_d = has_dest_q;
      dest_d     = dest_q;
      data_d     = data_q;
      ret_en_d   = '0;
      ret_tgt_d  = '0;
      ret_data_d = '0;
      ret_wr_d   = '0;

      for (int i = 0; i < 4; i++) begin
         idx = head_q + TagW'(i);
         if ((TagW+1)'(i) < commit_n) begin
            ret_en_d[3-i]                    = has_dest_q[idx];
            ret_tgt_d[4*(3-i) +: 4]          = dest_q[idx];
            ret_data_d[DataW*(3-i) +: DataW] = data_q[idx];
            ret_wr_d[TagW*(3-i) +: TagW]     = idx;
         end
      end

      // Ascending lane order lets the higher lane win on a duplicate tag
      for (int l = 0; l < 4; l++) begin
         idx = cdb_tag_flat_i[TagW*(3-l) +: TagW];
         if (cdb_valid_flat_i[3-l] && valid_q[idx]) begin
            done_d[idx] = 1'b1;
            data_d[idx] = cdb_data_flat_i[DataW*(3-l) +: DataW];
         end
      end

      for (int i = 0; i < 4; i++) begin
         idx = head_q + TagW'(i);
         if ((TagW+1)'(i) < commit_n) begin
            valid_d[idx] = 1'b0;
            done_d[idx]  = 1'b0;
         end
      end

      for (int i = 0; i < 4; i++) begin
         idx = tail_q + TagW'(i);
         if ((TagW+1)'(i) < alloc_n) begin
            valid_d[idx]    = 1'b1;
            done_d[idx]     = 1'b0;
            has_dest_d[idx] = alloc_has_dest_flat_i[3-i];
            dest_d[idx]     = alloc_dest_flat_i[4*(3-i) +: 4];
         end
      end

      head_d  = head_q + TagW'(commit_n);
      tail_d  = tail_q + TagW'(alloc_n);
      count_d = count_q + alloc_n - commit_n;
   end

   // Control state and retirement port; flush recovers exactly like reset
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         valid_q    <= '0;
         done_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         ret_en_q   <= '0;
         ret_tgt_q  <= '0;
         ret_data_q <= '0;
         ret_wr_q   <= '0;
      end else begin
         valid_q    <= valid_d;
         done_q     <= done_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ret_en_q   <= ret_en_d;
         ret_tgt_q  <= ret_tgt_d;
         ret_data_q <= ret_data_d;
         ret_wr_q   <= ret_wr_d;
      end
   end

   // Payload storage is only meaningful while valid, so it needs no reset
   always_ff @(posedge clk_i) begin
      has_dest_q <= has_dest_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst, flush, alloc_valid;
   logic [2:0]  alloc_count;
   logic [3:0]  alloc_has_dest;
   logic [15:0] alloc_dest;
   logic        alloc_ready;
   logic [15:0] alloc_tag;
   logic [3:0]  cdb_valid;
   logic [15:0] cdb_tag;
   logic [63:0] cdb_data;
   logic [3:0]  ret_en;
   logic [15:0] ret_tgt;
   logic [63:0] ret_data;
   logic [15:0] ret_wr;
   logic [4:0]  rob_count;
   logic        rob_empty, rob_full;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk_i                               (clk),
      .rst_i                               (rst),
      .flush_i                             (flush),
      .alloc_valid_i                       (alloc_valid),
      .alloc_count_i                       (alloc_count),
      .alloc_has_dest_flat_i               (alloc_has_dest),
      .alloc_dest_flat_i                   (alloc_dest),
      .alloc_ready_o                       (alloc_ready),
      .alloc_tag_flat_o                    (alloc_tag),
      .cdb_valid_flat_i                    (cdb_valid),
      .cdb_tag_flat_i                      (cdb_tag),
      .cdb_data_flat_i                     (cdb_data),
      .retirement_write_data_enable_flat_o (ret_en),
      .retirement_target_reg_flat_o        (ret_tgt),
      .retirement_write_data_flat_o        (ret_data),
      .instruction_writer_flat_o           (ret_wr),
      .rob_count_o                         (rob_count),
      .rob_empty_o                         (rob_empty),
      .rob_full_o                          (rob_full)
   );

   // Model: live entries in program order
   typedef struct {
      int tag;
      bit has_dest;
      int dest;
      bit done;
      int data;
   } ent_t;

   ent_t        q[$];
   int          m_tail;
   logic [3:0]  e_en;
   logic [15:0] e_tgt, e_wr;
   logic [63:0] e_data;
   int          n_checks, n_fail;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int k;
      int n;
      bit ready;
      e_en = '0; e_tgt = '0; e_wr = '0; e_data = '0;
      if (rst || flush) begin
         q.delete();
         m_tail = 0;
         return;
      end
      k = 0;
      while (k < 4 && k < q.size() && q[k].done) begin
         e_en[3-k]             = q[k].has_dest;
         e_tgt[4*(3-k) +: 4]   = 4'(q[k].dest);
         e_data[16*(3-k) +: 16] = 16'(q[k].data);
         e_wr[4*(3-k) +: 4]    = 4'(q[k].tag);
         k++;
      end
      for (int l = 0; l < 4; l++) begin
         if (cdb_valid[3-l]) begin
            foreach (q[j]) begin
               if (q[j].tag == int'(cdb_tag[4*(3-l) +: 4])) begin
                  q[j].done = 1'b1;
                  q[j].data = int'(cdb_data[16*(3-l) +: 16]);
               end
            end
         end
      end
      ready = (q.size() + 4 <= 16);
      repeat (k) void'(q.pop_front());
      if (alloc_valid && ready) begin
         n = (alloc_count > 4) ? 4 : int'(alloc_count);
         for (int i = 0; i < n; i++) begin
            ent_t e;
            e.tag      = (m_tail + i) % 16;
            e.has_dest = alloc_has_dest[3-i];
            e.dest     = int'(alloc_dest[4*(3-i) +: 4]);
            e.done     = 1'b0;
            e.data     = 0;
            q.push_back(e);
         end
         m_tail = (m_tail + n) % 16;
      end
   endtask

   task automatic check_all();
      logic [15:0] exp_tags;
      for (int i = 0; i < 4; i++) exp_tags[4*(3-i) +: 4] = 4'((m_tail + i) % 16);
      check_eq("count", 64'(rob_count), 64'(q.size()));
      check_eq("empty", 64'(rob_empty), 64'(q.size() == 0));
      check_eq("full", 64'(rob_full), 64'(q.size() == 16));
      check_eq("alloc_ready", 64'(alloc_ready), 64'(q.size() <= 12));
      check_eq("alloc_tag", 64'(alloc_tag), 64'(exp_tags));
      check_eq("ret_en", 64'(ret_en), 64'(e_en));
      check_eq("ret_tgt", 64'(ret_tgt), 64'(e_tgt));
      check_eq("ret_data", ret_data, e_data);
      check_eq("ret_wr", 64'(ret_wr), 64'(e_wr));
   endtask

   // Inputs are held from the previous post-edge point; advance one edge and compare
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      rst = 0; flush = 0; alloc_valid = 0; alloc_count = 0;
      alloc_has_dest = 0; alloc_dest = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
   endtask

   task automatic complete_tags(input logic [15:0] tags, input logic [63:0] data);
      idle_inputs();
      cdb_valid = 4'hF; cdb_tag = tags; cdb_data = data;
      cycle();
   endtask

   task automatic rand_cycle(input int alloc_pct, input int cdb_pct);
      idle_inputs();
      flush          = ($urandom_range(0, 99) == 0);
      alloc_valid    = ($urandom_range(0, 99) < alloc_pct);
      alloc_count    = 3'($urandom_range(0, 4));
      alloc_has_dest = 4'($urandom);
      alloc_dest     = 16'($urandom);
      cdb_data       = {$urandom, $urandom};
      for (int l = 0; l < 4; l++) begin
         cdb_valid[3-l] = ($urandom_range(0, 99) < cdb_pct);
         if (q.size() > 0 && $urandom_range(0, 7) != 0)
            cdb_tag[4*(3-l) +: 4] = 4'(q[$urandom_range(0, q.size() - 1)].tag);
         else
            cdb_tag[4*(3-l) +: 4] = 4'($urandom);
      end
      cycle();
   endtask

   initial begin
      n_checks = 0; n_fail = 0; m_tail = 0;
      idle_inputs();
      rst = 1;
      cycle();
      cycle();

      // In-order retirement with out-of-order completion in one cycle
      idle_inputs();
      alloc_valid = 1; alloc_count = 4; alloc_has_dest = 4'hF; alloc_dest = 16'h1234;
      cycle();
      complete_tags(16'h3210, 64'h000A_0014_001E_0028);
      idle_inputs();
      cycle();
      check_eq("t1_en", 64'(ret_en), 64'h0F);
      check_eq("t1_tgt", 64'(ret_tgt), 64'h1234);
      check_eq("t1_data", ret_data, 64'h0028_001E_0014_000A);
      check_eq("t1_wr", 64'(ret_wr), 64'h0123);
      cycle();
      check_eq("t1_pulse", 64'(ret_en), 64'h0);

      // Entry without destination still retires in order
      idle_inputs();
      alloc_valid = 1; alloc_count = 4; alloc_has_dest = 4'b1011; alloc_dest = 16'h5678;
      cycle();
      complete_tags(16'h4567, 64'h1111_2222_3333_4444);
      idle_inputs();
      cycle();
      check_eq("t5_en", 64'(ret_en), 64'b1011);
      check_eq("t5_wr", 64'(ret_wr), 64'h4567);

      // Flush with pending entries and a same-cycle completion
      idle_inputs();
      alloc_valid = 1; alloc_count = 4; alloc_has_dest = 4'hF;
      cycle();
      alloc_count = 2;
      cycle();
      idle_inputs();
      flush = 1; cdb_valid = 4'hF; cdb_tag = 16'h89AB; cdb_data = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
      check_eq("t6_empty", 64'(rob_empty), 64'h1);
      idle_inputs();
      repeat (3) cycle();

      // Random phases: fill-heavy, balanced, drain-heavy
      repeat (600) rand_cycle(90, 10);
      repeat (600) rand_cycle(50, 40);
      repeat (600) rand_cycle(30, 70);
      idle_inputs();
      rst = 1;
      cycle();
      repeat (400) rand_cycle(70, 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
